// File: rtl/mu_update_scheduler_pkg.sv
// Shared encodings for the adaptation controller and the mu update scheduler.
// Holds the phase codes, the scheduler FSM states and the update_mode values.
package mu_update_scheduler_pkg;

    localparam logic [2:0] PHASE_STARTUP = 3'd0;
    localparam logic [2:0] PHASE_CMA     = 3'd1;
    localparam logic [2:0] PHASE_LMS     = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMA_RUN = 2'd1,
        ST_LMS_RUN = 2'd2,
        ST_HOLD    = 2'd3
    } sched_state_e;

    typedef enum logic {
        MODE_CMA = 1'b0,
        MODE_LMS = 1'b1
    } update_mode_e;

    // Startup and every unassigned phase code park the scheduler in IDLE.
    function automatic sched_state_e phase_target(input logic [2:0] phase);
        case (phase)
            PHASE_STARTUP: return ST_IDLE;
            PHASE_CMA:     return ST_CMA_RUN;
            PHASE_LMS:     return ST_LMS_RUN;
            default:       return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mu_update_scheduler_decay.sv
// Step-size decay: counts accepted updates and bumps mu_shift every DECAY_PERIOD,
// saturating at MU_SHIFT_MAX; a run-state entry clears the count and may reload mu.
module mu_decay_counter #(
    parameter int DECAY_PERIOD = 8,
    parameter int MU_SHIFT_MAX = 14,
    parameter int RESET_SHIFT  = 6,
    parameter int SHIFT_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load_en,
    input  logic [SHIFT_W-1:0] load_val,
    input  logic               tick,
    output logic [SHIFT_W-1:0] mu_shift
);

    localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mu_shift <= SHIFT_W'(RESET_SHIFT);
        end else if (clear) begin
            cnt <= '0;
            if (load_en) mu_shift <= load_val;
        end else if (tick) begin
            if (cnt == CW'(DECAY_PERIOD - 1)) begin
                cnt <= '0;
                if (mu_shift < SHIFT_W'(MU_SHIFT_MAX)) mu_shift <= mu_shift + SHIFT_W'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mu_update_scheduler.sv
// Turns adaptation phase/iteration into a decimated, handshaked stream of
// tap-update requests carrying error mode, decaying mu_shift and an iteration tag.
module mu_update_scheduler
    import mu_update_scheduler_pkg::*;
#(
    parameter int UPDATE_DECIM      = 4,
    parameter int DECAY_PERIOD      = 8,
    parameter int CMA_MU_SHIFT_INIT = 6,
    parameter int LMS_MU_SHIFT_INIT = 8,
    parameter int MU_SHIFT_MAX      = 14,
    parameter int SHIFT_W           = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [2:0]         adaptation_phase,
    input  logic [31:0]        iteration_count,
    input  logic               sample_valid,
    input  logic               freeze,
    output logic               update_valid,
    input  logic               update_ready,
    output logic               update_mode,
    output logic [SHIFT_W-1:0] mu_shift,
    output logic [31:0]        update_tag,
    output logic               phase_change,
    output logic [15:0]        overrun_count
);

    localparam int DW = (UPDATE_DECIM > 1) ? $clog2(UPDATE_DECIM) : 1;

    sched_state_e      state, ret_state, target, nxt_state;
    logic              trans, running, dec_point, xfer, load_en;
    logic [DW-1:0]     dec_cnt;
    logic [SHIFT_W-1:0] cur_mu, load_val;

    // trans marks a real run-state change; HOLD entry/exit to the same state is not one.
    always_comb begin
        target    = phase_target(adaptation_phase);
        nxt_state = state;
        trans     = 1'b0;
        if (enable) begin
            if (state == ST_HOLD) begin
                if (!freeze) begin
                    nxt_state = target;
                    trans     = (target != ret_state);
                end
            end else if (freeze && state != ST_IDLE) begin
                nxt_state = ST_HOLD;
            end else if (target != state) begin
                nxt_state = target;
                trans     = 1'b1;
            end
        end
        running   = enable && (state == ST_CMA_RUN || state == ST_LMS_RUN) && (nxt_state == state);
        dec_point = running && sample_valid && (dec_cnt == DW'(UPDATE_DECIM - 1));
        xfer      = update_valid && update_ready;
        load_en   = (nxt_state == ST_CMA_RUN) || (nxt_state == ST_LMS_RUN);
        load_val  = (nxt_state == ST_LMS_RUN) ? SHIFT_W'(LMS_MU_SHIFT_INIT) : SHIFT_W'(CMA_MU_SHIFT_INIT);
    end

    mu_decay_counter #(
        .DECAY_PERIOD (DECAY_PERIOD),
        .MU_SHIFT_MAX (MU_SHIFT_MAX),
        .RESET_SHIFT  (CMA_MU_SHIFT_INIT),
        .SHIFT_W      (SHIFT_W)
    ) u_decay (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (trans),
        .load_en  (load_en),
        .load_val (load_val),
        .tick     (xfer && enable),
        .mu_shift (cur_mu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ret_state     <= ST_IDLE;
            dec_cnt       <= '0;
            update_valid  <= 1'b0;
            update_mode   <= MODE_CMA;
            mu_shift      <= SHIFT_W'(CMA_MU_SHIFT_INIT);
            update_tag    <= '0;
            phase_change  <= 1'b0;
            overrun_count <= '0;
        end else begin
            phase_change <= trans;
            state        <= nxt_state;
            if (state != ST_HOLD && nxt_state == ST_HOLD) ret_state <= state;

            if (trans)                        dec_cnt <= '0;
            else if (running && sample_valid) dec_cnt <= dec_point ? '0 : dec_cnt + DW'(1);

            // A same-cycle accept frees the slot, so the new request follows back-to-back.
            if (dec_point && (!update_valid || update_ready)) begin
                update_valid <= 1'b1;
                update_mode  <= (state == ST_LMS_RUN) ? MODE_LMS : MODE_CMA;
                mu_shift     <= cur_mu;
                update_tag   <= iteration_count;
            end else if (xfer) begin
                update_valid <= 1'b0;
            end

            if (dec_point && update_valid && !update_ready && overrun_count != 16'hFFFF)
                overrun_count <= overrun_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mu_update_scheduler.sv
// Bench for mu_update_scheduler: directed phase/freeze/reset scenarios plus random
// traffic, all checked every cycle against a sample/transfer-count reference model.
module tb_mu_update_scheduler;

    localparam int DECIM = 4, DP = 8, CMA_INIT = 6, LMS_INIT = 8, MU_MAX = 14;
    localparam int S_IDLE = 0, S_CMA = 1, S_LMS = 2, S_HOLD = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        enable = 1'b0, sample_valid = 1'b0, freeze = 1'b0, update_ready = 1'b0;
    logic [2:0]  adaptation_phase = 3'd0;
    logic [31:0] iteration_count = '0;
    logic        update_valid, update_mode, phase_change;
    logic [3:0]  mu_shift;
    logic [31:0] update_tag;
    logic [15:0] overrun_count;

    int n_chk = 0, n_pass = 0;

    mu_update_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .adaptation_phase(adaptation_phase),
        .iteration_count(iteration_count), .sample_valid(sample_valid), .freeze(freeze),
        .update_valid(update_valid), .update_ready(update_ready), .update_mode(update_mode),
        .mu_shift(mu_shift), .update_tag(update_tag), .phase_change(phase_change),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    // Reference model: state, samples since entry, transfers since mu (re)base.
    int          m_st = S_IDLE, m_ret = S_IDLE, m_nsamp = 0, m_nx = 0, m_base = CMA_INIT;
    int          m_ovr = 0;
    logic        m_v = 0, m_mode = 0, m_pc = 0;
    int          m_mu = CMA_INIT;
    logic [31:0] m_tag = '0;

    function automatic int mu_now(input int base, input int nx);
        int v;
        v = base + nx / DP;
        return (v > MU_MAX) ? MU_MAX : v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_st = S_IDLE; m_ret = S_IDLE; m_nsamp = 0; m_nx = 0; m_base = CMA_INIT;
                m_ovr = 0; m_v = 0; m_mode = 0; m_pc = 0; m_mu = CMA_INIT; m_tag = '0;
            end else begin
                int tgt, nst;
                bit tr, xf, run, fire, old_v;
                tgt = (adaptation_phase == 3'd1) ? S_CMA : (adaptation_phase == 3'd2) ? S_LMS : S_IDLE;
                nst = m_st; tr = 0;
                if (enable) begin
                    if (m_st == S_HOLD) begin
                        if (!freeze) begin nst = tgt; tr = (tgt != m_ret); end
                    end else if (freeze && m_st != S_IDLE) nst = S_HOLD;
                    else if (tgt != m_st) begin nst = tgt; tr = 1; end
                end
                old_v = m_v;
                xf    = m_v && update_ready;
                run   = enable && (m_st == S_CMA || m_st == S_LMS) && nst == m_st;
                fire  = run && sample_valid && ((m_nsamp + 1) % DECIM == 0);
                if (fire && (!old_v || update_ready)) begin
                    m_v = 1; m_mode = (m_st == S_LMS); m_mu = mu_now(m_base, m_nx); m_tag = iteration_count;
                end else if (xf) m_v = 0;
                if (fire && old_v && !update_ready && m_ovr < 65535) m_ovr++;
                if (tr) m_nsamp = 0;
                else if (run && sample_valid) m_nsamp++;
                if (tr) begin
                    m_base = (nst == S_CMA) ? CMA_INIT : (nst == S_LMS) ? LMS_INIT : mu_now(m_base, m_nx);
                    m_nx = 0;
                end else if (xf && enable) m_nx++;
                if (nst == S_HOLD && m_st != S_HOLD) m_ret = m_st;
                m_pc = tr;
                m_st = nst;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("valid", update_valid, m_v);
                chk("phase_change", phase_change, m_pc);
                chk("overrun", overrun_count, m_ovr);
                if (m_v) begin
                    chk("mode", update_mode, m_mode);
                    chk("mu_shift", mu_shift, m_mu);
                    chk("tag", update_tag, m_tag);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            iteration_count = $urandom;
        end
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!update_valid && k < 200) begin step(1); k++; end
        if (!update_valid) chk(nm, 0, 1);
    endtask

    initial begin
        int mus[1:90];
        int nv, npc, k;
        step(2);
        chk("rst valid", update_valid, 0);
        chk("rst mu", mu_shift, CMA_INIT);
        chk("rst ovr", overrun_count, 0);
        chk("rst pc", phase_change, 0);
        rst_n = 1;

        // CMA at full rate: pulse, then decay 6..14 and saturation.
        adaptation_phase = 3'd1; enable = 1; sample_valid = 1; update_ready = 1;
        step(1);
        chk("enter pc", phase_change, 1);
        for (int i = 1; i <= 90; i++) begin
            wait_valid("wait cma req");
            mus[i] = int'(mu_shift);
            step(1);
        end
        chk("xf1 mu", mus[1], 6);
        chk("xf8 mu", mus[8], 6);
        chk("xf9 mu", mus[9], 7);
        chk("xf65 mu", mus[65], 14);
        chk("xf90 mu", mus[90], 14);

        // CMA->LMS while a request is stalled: fields hold, two drops.
        update_ready = 0;
        wait_valid("wait stall req");
        adaptation_phase = 3'd2;
        step(10);
        chk("stall mode", update_mode, 0);
        chk("stall ovr", overrun_count, 2);
        update_ready = 1;
        step(1);
        wait_valid("wait lms req");
        chk("lms mode", update_mode, 1);
        chk("lms mu", mu_shift, 8);

        // Freeze at mu 9 in LMS.
        k = 0;
        while (!(update_valid && mu_shift == 4'd9) && k < 200) begin step(1); k++; end
        chk("reach mu9", mu_shift, 9);
        freeze = 1;
        nv = 0; npc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            nv += int'(update_valid); npc += int'(phase_change);
        end
        chk("frozen reqs", nv, 0);
        chk("frozen pc", npc, 0);
        freeze = 0;
        wait_valid("wait thaw req");
        chk("thaw mu", mu_shift, 9);

        // Backward move, then illegal phase to IDLE with a request pending.
        adaptation_phase = 3'd1;
        step(2);
        update_ready = 0;
        wait_valid("wait back req");
        chk("back mode", update_mode, 0);
        chk("back mu", mu_shift, 6);
        adaptation_phase = 3'd5;
        step(1);
        chk("idle pc", phase_change, 1);
        chk("idle pending", update_valid, 1);
        update_ready = 1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin step(1); nv += int'(update_valid); end
        chk("idle reqs", nv, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if ($urandom_range(0, 19) == 0) begin
                k = $urandom_range(0, 9);
                adaptation_phase = (k < 4) ? 3'd1 : (k < 8) ? 3'd2 : (k == 8) ? 3'd0 : 3'($urandom_range(3, 7));
            end
            if ($urandom_range(0, 14) == 0) freeze = ~freeze;
            enable       = ($urandom_range(0, 7) != 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            update_ready = $urandom_range(0, 1) != 0;
        end

        // Reset in the middle of an accepted transfer.
        enable = 1; freeze = 0; adaptation_phase = 3'd1; sample_valid = 1; update_ready = 0;
        step(1);
        wait_valid("wait final req");
        update_ready = 1;
        #2 rst_n = 0;
        #1;
        chk("mid rst valid", update_valid, 0);
        chk("mid rst mu", mu_shift, 6);
        chk("mid rst ovr", overrun_count, 0);
        chk("mid rst tag", update_tag, 0);
        step(2);
        rst_n = 1;
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
